comb_stack: RTL
===============

// Module: comb_stack
// PURPOSE
//  LIFO frame store for the recursive-combination engine. Holds (n,k) call frames.
//  Driven directly by the combination FSM's push/pop/top strobes.
//  Returns the top frame and the empty status the FSM branches on.
//  Sits between the FSM and the arithmetic datapath: the datapath supplies push
//  data; the top frame feeds back into the datapath operand muxes.
// PARAMETERS
//  WIDTH   8   bits per field (n and k each)
//  DEPTH   32  max frames; must be a power of 2, >= 2
//  ADDR_W  5   log2(DEPTH)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  push       in   1         write {n_in,k_in} as new top frame
//  pop        in   1         discard top frame
//  top        in   1         load top frame into n_out/k_out
//  n_in       in   WIDTH     frame field n to push
//  k_in       in   WIDTH     frame field k to push
//  n_out      out  WIDTH     registered top-frame n
//  k_out      out  WIDTH     registered top-frame k
//  empty      out  1         count==0, combinational from count register
//  full       out  1         count==DEPTH
//  count      out  ADDR_W+1  frames currently stored
//  overflow   out  1         sticky: push attempted while full
//  underflow  out  1         one-cycle pulse: pop attempted while empty
//  max_depth  out  ADDR_W+1  high-water mark (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): count=0, n_out=k_out=0, overflow=0, underflow=0,
//    max_depth=0. Frame RAM contents are not cleared. rst overrides all strobes.
//  - Entries: mem[0..count-1]; the top frame is mem[count-1].
//  - top: if !empty, n_out/k_out <= mem[count-1] at the edge (1-cycle latency).
//    If empty, n_out/k_out hold their value; no flag is raised.
//  - push only: if !full, mem[count] <= {n_in,k_in}, count+1.
//    If full: frame dropped, count unchanged, overflow <= 1 (sticky until rst).
//  - pop only: if !empty, count-1.
//    If empty: count unchanged, underflow=1 for one cycle.
//    The FSM's terminating pop on an empty stack is legal; underflow is informational.
//  - push & pop: replace top.
//    If !empty: mem[count-1] <= input, count unchanged.
//    If empty: behaves as push only.
//  - top & pop: n_out/k_out capture the pre-pop top, then count-1 in the same edge.
//  - top & push: n_out/k_out capture the pre-push top (old frame). If empty, they hold.
//  - empty/full are derived from the registered count and reflect state before the
//    current edge. The FSM samples empty in its pop cycle, so it sees the pre-pop status.
//  - All outputs except empty/full are registered. No combinational path from any
//    input to any output.
//  - count never exceeds DEPTH and never wraps below 0.
// CONFIGURATION
//  COMB_STACK_HWM_EN defined:
//   - max_depth <= max(max_depth, next count) every cycle.
//   - Cleared only by rst.
//  COMB_STACK_HWM_EN undefined:
//   - max_depth is tied to 0 and no tracking logic is built.
//   - The port stays present, so instantiations are unchanged.
// TESTING
//  1 rst; push (5,2); top -> next cycle n_out=5, k_out=2, count=1, empty=0
//  2 push (5,2),(4,1),(4,2); top+pop x3 -> outputs (4,2),(4,1),(5,2); then empty=1
//  3 fill to DEPTH=32, push (9,9) -> full=1, count=32, overflow=1 sticky; top still
//    returns the 32nd frame; after rst overflow=0
//  4 empty stack: pop -> underflow=1 for one cycle, count=0; top -> n_out/k_out unchanged
//  5 count=3, push (7,3) & pop together -> count=3; top -> (7,3)
//  6 with COMB_STACK_HWM_EN: push x6, pop x4, push x2 -> max_depth=6;
//    without the macro -> max_depth=0; rst mid-fill -> count=0, empty=1 next cycle

Source files
------------

// File: rtl/comb_stack.sv
// LIFO store of (n,k) call frames for the recursive-combination engine.
// Optional high-water-mark tracking on max_depth is built when COMB_STACK_HWM_EN is defined.
module comb_stack #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              top,
  input  logic [WIDTH-1:0]  n_in,
  input  logic [WIDTH-1:0]  k_in,
  output logic [WIDTH-1:0]  n_out,
  output logic [WIDTH-1:0]  k_out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   max_depth
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  mem_n [DEPTH];
  logic [WIDTH-1:0]  mem_k [DEPTH];

  logic [ADDR_W-1:0] top_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   next_count;
  logic              do_write;
  logic              overflow_set;
  logic              underflow_set;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  // When count == DEPTH the low address bits are zero, so the wrap yields DEPTH-1.
  assign top_addr = count[ADDR_W-1:0] - ADDR_W'(1);

  always_comb begin
    next_count    = count;
    do_write      = 1'b0;
    wr_addr       = count[ADDR_W-1:0];
    overflow_set  = 1'b0;
    underflow_set = 1'b0;
    if (push && pop && !empty) begin
      do_write = 1'b1;
      wr_addr  = top_addr;
    end else if (push) begin
      if (!full) begin
        do_write   = 1'b1;
        next_count = count + (ADDR_W+1)'(1);
      end else begin
        overflow_set = 1'b1;
      end
    end else if (pop) begin
      if (!empty) begin
        next_count = count - (ADDR_W+1)'(1);
      end else begin
        underflow_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      n_out     <= '0;
      k_out     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= next_count;
      underflow <= underflow_set;
      if (overflow_set) begin
        overflow <= 1'b1;
      end
      if (top && !empty) begin
        n_out <= mem_n[top_addr];
        k_out <= mem_k[top_addr];
      end
    end
  end

  // Frame RAM is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem_n[wr_addr] <= n_in;
      mem_k[wr_addr] <= k_in;
    end
  end

`ifdef COMB_STACK_HWM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      max_depth <= '0;
    end else if (next_count > max_depth) begin
      max_depth <= next_count;
    end
  end
`else
  assign max_depth = '0;
`endif

endmodule
